frame_sequencer: RTL and testbench

Per-frame controller for the 160x120 side-scroller. On every frame tick it sequences the shared VGA pixel-write port through erase, physics update, collision check and redraw of the player sprite and the obstacle column. It owns all game state: player height, obstacle position and gap, score and game-over. It sits between the active-high flap button and the `vga_adapter` `x`/`y`/`colour`/`plot` inputs.

---
 rtl/frame_sequencer_if.sv | 14 +
 rtl/frame_sequencer.sv | 145 ++++++++++++++
 tb/tb_frame_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_sequencer_if.sv
// Pixel-write port toward vga_adapter plus the flap / score / game-over lines of
// frame_sequencer. The sequencer drives through "master"; the display side uses "slave".
interface frame_sequencer_if;
    logic       flap;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       game_over;
    logic [7:0] score;

    modport master (input flap, output x, y, colour, plot, game_over, score);
    modport slave (output flap, input x, y, colour, plot, game_over, score);
endinterface

// File: rtl/frame_sequencer.sv
// Per-frame side-scroller controller: on each frame tick it erases, moves, collision-checks
// and redraws the player and obstacle column through a single registered pixel port.
module frame_sequencer #(
    parameter int unsigned FRAME_DIV   = 833333,
    parameter int unsigned PLAYER_X    = 20,
    parameter int unsigned PLAYER_SIZE = 4,
    parameter int unsigned OBS_W       = 8,
    parameter int unsigned GAP_H       = 40,
    parameter int unsigned JUMP        = 8
) (
    input  logic              clock,
    input  logic              reset,
    frame_sequencer_if.master vga
);
    localparam int unsigned     ScrW       = 160;
    localparam int unsigned     ScrH       = 120;
    localparam int unsigned     CntW       = $clog2(FRAME_DIV);
    localparam logic [CntW-1:0] TickAt     = CntW'(FRAME_DIV - 1);
    localparam logic [6:0]      PlayerMaxY = 7'(ScrH - PLAYER_SIZE);
    localparam logic [7:0]      ObsStartX  = 8'(ScrW - OBS_W);
    localparam int unsigned     GapRange   = ScrH - GAP_H;

    typedef enum logic [2:0] {
        StIdle, StEraseP, StEraseO, StMove, StCheck, StDrawP, StDrawO, StGameOver
    } state_e;

    state_e          state;
    logic [CntW-1:0] frame_cnt;
    logic            flap_prev;
    logic            flap_pend;
    logic            hit;
    logic [6:0]      player_y;
    logic [6:0]      gap_top;
    logic [7:0]      obs_x;
    // Sprite walk position: col within a row, row within the sprite / column.
    logic [7:0]      col;
    logic [6:0]      row;

    logic       tick, flap_edge;
    logic       p_col_end, p_last, o_col_end, o_last, in_gap;
    logic       x_overlap, y_outside, on_floor;
    logic [6:0] jumped_y, fallen_y, next_gap;

    always_comb begin
        tick      = frame_cnt == TickAt;
        flap_edge = vga.flap && !flap_prev;
        p_col_end = col == 8'(PLAYER_SIZE - 1);
        p_last    = p_col_end && (row == 7'(PLAYER_SIZE - 1));
        o_col_end = col == 8'(OBS_W - 1);
        o_last    = o_col_end && (row == 7'(ScrH - 1));
        in_gap    = (row >= gap_top) && ({1'b0, row} < ({1'b0, gap_top} + 8'(GAP_H)));
        x_overlap = (9'(PLAYER_X + PLAYER_SIZE) > {1'b0, obs_x}) &&
                    (9'(PLAYER_X) < ({1'b0, obs_x} + 9'(OBS_W)));
        y_outside = (player_y < gap_top) ||
                    (({1'b0, player_y} + 8'(PLAYER_SIZE)) > ({1'b0, gap_top} + 8'(GAP_H)));
        on_floor  = player_y == PlayerMaxY;
        jumped_y  = (player_y >= 7'(JUMP)) ? player_y - 7'(JUMP) : 7'd0;
        fallen_y  = (player_y < PlayerMaxY) ? player_y + 7'd1 : PlayerMaxY;
        next_gap  = 7'((32'(gap_top) + 32'd29) % GapRange);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= StIdle;
            frame_cnt     <= '0;
            flap_prev     <= 1'b0;
            flap_pend     <= 1'b0;
            hit           <= 1'b0;
            player_y      <= 7'd60;
            obs_x         <= ObsStartX;
            gap_top       <= 7'd40;
            col           <= '0;
            row           <= '0;
            vga.x         <= '0;
            vga.y         <= '0;
            vga.colour    <= '0;
            vga.plot      <= 1'b0;
            vga.game_over <= 1'b0;
            vga.score     <= '0;
        end else begin
            frame_cnt <= tick ? '0 : frame_cnt + CntW'(1);
            flap_prev <= vga.flap;
            vga.plot  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (tick) state <= StEraseP;
                end
                StEraseP, StDrawP: begin
                    vga.x      <= 8'(PLAYER_X) + col;
                    vga.y      <= player_y + row;
                    vga.colour <= (state == StDrawP) ? 3'b110 : 3'b000;
                    vga.plot   <= 1'b1;
                    if (p_last) begin
                        col   <= '0;
                        row   <= '0;
                        state <= (state == StDrawP) ? StDrawO : StEraseO;
                    end else if (p_col_end) begin
                        col <= '0;
                        row <= row + 7'd1;
                    end else begin
                        col <= col + 8'd1;
                    end
                end
                StEraseO, StDrawO: begin
                    vga.x      <= obs_x + col;
                    vga.y      <= row;
                    vga.colour <= (state == StDrawO) ? 3'b010 : 3'b000;
                    vga.plot   <= (state == StEraseO) || !in_gap;
                    if (o_last) begin
                        col <= '0;
                        row <= '0;
                        if (state == StEraseO) state <= StMove;
                        else                   state <= hit ? StGameOver : StIdle;
                    end else if (o_col_end) begin
                        col <= '0;
                        row <= row + 7'd1;
                    end else begin
                        col <= col + 8'd1;
                    end
                end
                StMove: begin
                    player_y  <= flap_pend ? jumped_y : fallen_y;
                    flap_pend <= 1'b0;
                    if (obs_x == 8'd0) begin
                        obs_x     <= ObsStartX;
                        gap_top   <= next_gap;
                        vga.score <= vga.score + 8'd1;
                    end else begin
                        obs_x <= obs_x - 8'd1;
                    end
                    state <= StCheck;
                end
                StCheck: begin
                    hit   <= on_floor || (x_overlap && y_outside);
                    state <= StDrawP;
                end
                StGameOver: begin
                    vga.game_over <= 1'b1;
                end
            endcase
            // Placed after the case so an edge seen during MOVE stays pending for the next frame.
            if (flap_edge && (state != StGameOver)) flap_pend <= 1'b1;
        end
    end
endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: a default-geometry instance driven from a table of flap frames
// plus a mid-frame reset, and a shrunk-geometry instance run long enough to wrap and crash.
module tb_frame_sequencer;
    typedef struct {
        int fd; int px; int ps; int ow; int gh; int jump;
    } cfg_t;
    typedef struct {
        int py; int ox; int gt; int score; bit over; bit pend;
    } gs_t;
    typedef struct packed {
        logic [7:0] x; logic [6:0] y; logic [2:0] c;
    } wr_t;
    typedef struct {
        bit flap; int top_y; int n_erase; int n_player; int n_obs; int score;
    } vec_t;

    localparam int AFd = 2001;
    // Narrow sprites keep a frame short enough that a full obstacle pass fits the run.
    localparam int BFd = 270;
    localparam int BPs = 2;
    localparam int BOw = 1;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    frame_sequencer_if bus_a ();
    frame_sequencer_if bus_b ();

    frame_sequencer #(.FRAME_DIV(AFd)) dut_a (
        .clock(clk),
        .reset(rst_a),
        .vga  (bus_a)
    );

    frame_sequencer #(
        .FRAME_DIV  (BFd),
        .PLAYER_X   (20),
        .PLAYER_SIZE(BPs),
        .OBS_W      (BOw),
        .GAP_H      (40),
        .JUMP       (8)
    ) dut_b (
        .clock(clk),
        .reset(rst_b),
        .vga  (bus_b)
    );

    wr_t cap_a[$], cap_b[$], exp_a[$], exp_b[$];
    int  n_vec = 0;
    int  n_bad = 0;

    always @(negedge clk) begin
        if (!rst_a && bus_a.plot) cap_a.push_back({bus_a.x, bus_a.y, bus_a.colour});
        if (!rst_b && bus_b.plot) cap_b.push_back({bus_b.x, bus_b.y, bus_b.colour});
    end

    function automatic wr_t mk(int x, int y, int c);
        wr_t w;
        w.x = 8'(x);
        w.y = 7'(y);
        w.c = 3'(c);
        return w;
    endfunction

    function automatic void push_exp(int inst, wr_t w);
        if (inst == 0) exp_a.push_back(w);
        else           exp_b.push_back(w);
    endfunction

    function automatic gs_t reset_state(cfg_t c);
        gs_t s;
        s.py = 60; s.ox = 160 - c.ow; s.gt = 40; s.score = 0; s.over = 0; s.pend = 0;
        return s;
    endfunction

    // Whole-frame reference: list every pixel the frame should write, then apply the rules.
    task automatic model_frame(input int inst, input cfg_t c, inout gs_t s);
        bit hit;
        if (s.over) return;
        for (int r = 0; r < c.ps; r++)
            for (int k = 0; k < c.ps; k++) push_exp(inst, mk(c.px + k, s.py + r, 0));
        for (int r = 0; r < 120; r++)
            for (int k = 0; k < c.ow; k++) push_exp(inst, mk(s.ox + k, r, 0));
        if (s.pend) s.py = (s.py - c.jump < 0) ? 0 : s.py - c.jump;
        else        s.py = (s.py + 1 > 120 - c.ps) ? 120 - c.ps : s.py + 1;
        s.pend = 0;
        if (s.ox == 0) begin
            s.ox    = 160 - c.ow;
            s.gt    = (s.gt + 29) % (120 - c.gh);
            s.score = (s.score + 1) % 256;
        end else begin
            s.ox = s.ox - 1;
        end
        hit = (s.py == 120 - c.ps) ||
              ((c.px + c.ps > s.ox) && (c.px < s.ox + c.ow) &&
               ((s.py < s.gt) || (s.py + c.ps > s.gt + c.gh)));
        for (int r = 0; r < c.ps; r++)
            for (int k = 0; k < c.ps; k++) push_exp(inst, mk(c.px + k, s.py + r, 6));
        for (int r = 0; r < 120; r++)
            if (r < s.gt || r >= s.gt + c.gh)
                for (int k = 0; k < c.ow; k++) push_exp(inst, mk(s.ox + k, r, 2));
        if (hit) s.over = 1;
    endtask

    task automatic chk(input string name, input int got, input int req);
        n_vec++;
        if (got != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic check_frame(input int inst, input int frame);
        int  ng, ne, bad_at;
        wr_t g, e;
        ng     = (inst == 0) ? cap_a.size() : cap_b.size();
        ne     = (inst == 0) ? exp_a.size() : exp_b.size();
        bad_at = -1;
        g      = '0;
        e      = '0;
        for (int i = 0; i < ng && i < ne && bad_at < 0; i++) begin
            if (inst == 0) begin g = cap_a[i]; e = exp_a[i]; end
            else begin g = cap_b[i]; e = exp_b[i]; end
            if (g != e) bad_at = i;
        end
        if (bad_at < 0 && ng != ne) bad_at = (ng < ne) ? ng : ne;
        n_vec++;
        if (bad_at >= 0) begin
            n_bad++;
            $display("FAIL stream dut%0d frame %0d: %0d writes vs %0d required; at %0d got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                     inst, frame, ng, ne, bad_at, g.x, g.y, g.c, e.x, e.y, e.c);
        end
        if (inst == 0) begin cap_a.delete(); exp_a.delete(); end
        else begin cap_b.delete(); exp_b.delete(); end
    endtask

    function automatic void stats_a(output int top_y, output int n_er, output int n_pl,
                                    output int n_ob);
        top_y = -1; n_er = 0; n_pl = 0; n_ob = 0;
        foreach (cap_a[i]) begin
            if (cap_a[i].c == 3'b000) n_er++;
            if (cap_a[i].c == 3'b010) n_ob++;
            if (cap_a[i].c == 3'b110) begin
                n_pl++;
                if (top_y < 0 || int'(cap_a[i].y) < top_y) top_y = int'(cap_a[i].y);
            end
        end
    endfunction

    // Each process sits on a falling edge, pos rising edges after its reset release.
    task automatic step_to(inout int pos, input int target);
        repeat (target - pos) @(negedge clk);
        pos = target;
    endtask

    task automatic pulse(input int inst, inout int pos);
        if (inst == 0) bus_a.flap = 1'b1; else bus_b.flap = 1'b1;
        step_to(pos, pos + 2);
        if (inst == 0) bus_a.flap = 1'b0; else bus_b.flap = 1'b0;
        step_to(pos, pos + 2);
    endtask

    task automatic run_a();
        cfg_t c;
        gs_t  s;
        vec_t tbl[10];
        int   pos, seq, top_y, n_er, n_pl, n_ob;
        c   = '{fd: AFd, px: 20, ps: 4, ow: 8, gh: 40, jump: 8};
        seq = 2 * c.ps * c.ps + 2 * 120 * c.ow + 2;
        // {flap before tick, drawn top row, erase writes, player writes, obstacle writes, score}
        tbl = '{'{0, 61, 976, 16, 640, 0}, '{1, 53, 976, 16, 640, 0},
                '{1, 45, 976, 16, 640, 0}, '{1, 37, 976, 16, 640, 0},
                '{1, 29, 976, 16, 640, 0}, '{1, 21, 976, 16, 640, 0},
                '{1, 13, 976, 16, 640, 0}, '{1,  5, 976, 16, 640, 0},
                '{1,  0, 976, 16, 640, 0}, '{0,  1, 976, 16, 640, 0}};
        s = reset_state(c);
        bus_a.flap = 1'b0;
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        pos = 0;
        chk("a reset plot", int'(bus_a.plot), 0);
        chk("a reset score", int'(bus_a.score), 0);
        chk("a reset game_over", int'(bus_a.game_over), 0);
        chk("a reset x", int'(bus_a.x), 0);
        step_to(pos, c.fd);
        chk("a writes before first tick", cap_a.size(), 0);
        step_to(pos, c.fd + 1);
        chk("a first pixel after tick", int'(bus_a.plot), 1);
        for (int k = 1; k <= 10; k++) begin
            if (tbl[k-1].flap) begin
                pulse(0, pos);
                s.pend = 1;
            end
            step_to(pos, k * c.fd - 1 + seq + 8);
            model_frame(0, c, s);
            stats_a(top_y, n_er, n_pl, n_ob);
            chk($sformatf("a frame %0d player top", k), top_y, tbl[k-1].top_y);
            chk($sformatf("a frame %0d erase writes", k), n_er, tbl[k-1].n_erase);
            chk($sformatf("a frame %0d player writes", k), n_pl, tbl[k-1].n_player);
            chk($sformatf("a frame %0d obstacle writes", k), n_ob, tbl[k-1].n_obs);
            chk($sformatf("a frame %0d score", k), int'(bus_a.score), tbl[k-1].score);
            chk($sformatf("a frame %0d game_over", k), int'(bus_a.game_over), int'(s.over));
            check_frame(0, k);
        end
        // Reset in the middle of the next frame's obstacle redraw.
        step_to(pos, 11 * c.fd - 1 + 1500);
        rst_a = 1'b1;
        step_to(pos, pos + 1);
        chk("a mid-reset plot", int'(bus_a.plot), 0);
        chk("a mid-reset colour", int'(bus_a.colour), 0);
        chk("a mid-reset y", int'(bus_a.y), 0);
        chk("a mid-reset score", int'(bus_a.score), 0);
        cap_a.delete();
        exp_a.delete();
        rst_a = 1'b0;
        pos = 0;
        s = reset_state(c);
        step_to(pos, c.fd - 1 + seq + 8);
        model_frame(0, c, s);
        check_frame(0, 100);
        chk("a post-reset game_over", int'(bus_a.game_over), 0);
    endtask

    task automatic run_b();
        cfg_t c;
        gs_t  s;
        int   pos, seq, post;
        bit   want;
        c    = '{fd: BFd, px: 20, ps: BPs, ow: BOw, gh: 40, jump: 8};
        seq  = 2 * c.ps * c.ps + 2 * 120 * c.ow + 2;
        s    = reset_state(c);
        post = 0;
        bus_b.flap = 1'b0;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        pos = 0;
        chk("b reset plot", int'(bus_b.plot), 0);
        for (int k = 1; k <= 250; k++) begin
            want = 0;
            if (s.over) begin
                want = bit'($urandom_range(0, 1));
            end else if (k <= 165) begin
                // Steer around mid-gap with random jitter until past the wrap, then let it fall.
                want = s.py > 58 + int'($urandom_range(0, 8));
                if (s.py > 52 && $urandom_range(0, 7) == 0) want = 1;
            end
            if (want) begin
                pulse(1, pos);
                if (!s.over) s.pend = 1;
            end
            step_to(pos, k * c.fd - 1 + seq + 8);
            model_frame(1, c, s);
            check_frame(1, k);
            chk($sformatf("b frame %0d score", k), int'(bus_b.score), s.score);
            chk($sformatf("b frame %0d game_over", k), int'(bus_b.game_over), int'(s.over));
            if (s.over) post++;
            if (post >= 4) break;
        end
        chk("b final score", int'(bus_b.score), 1);
        chk("b final game_over", int'(bus_b.game_over), 1);
    endtask

    initial begin
        fork
            run_a();
            run_b();
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end
endmodule
